// File: rtl/orion_sync_demux_src.sv
// Clocked source for a two-phase bundled-data demux: buffers {data, sel}
// tokens and replays each as one transition on the A and Sel request lines.
module orion_sync_demux_src #(
    parameter int   WIDTH        = 1,
    parameter int   DEPTH        = 4,
    parameter int   SETUP_CYCLES = 1,
    parameter int   SYNC_STAGES  = 2,
    parameter logic REQ_INIT     = 1'b0,
    parameter int   CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel,
    output logic                   outA_req,
    input  logic                   outA_ack,
    output logic [WIDTH-1:0]       outA_data,
    output logic                   outSel_req,
    input  logic                   outSel_ack,
    output logic                   outSel_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_WIDTH-1:0]   tokens_sent
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [WIDTH:0]           mem_q [DEPTH];
    logic [WIDTH:0]           mem_d [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     in_ready_q, in_ready_d;

    logic [SYNC_STAGES-1:0]   ack_a_sync_q, ack_a_sync_d;
    logic [SYNC_STAGES-1:0]   ack_s_sync_q, ack_s_sync_d;

    logic [1:0]               state_q, state_d;
    logic [SCW-1:0]           setup_cnt_q, setup_cnt_d;
    logic                     req_a_q, req_a_d;
    logic                     req_s_q, req_s_d;
    logic [WIDTH-1:0]         data_q, data_d;
    logic                     sel_q, sel_d;
    logic [CNT_WIDTH-1:0]     sent_q, sent_d;

    logic                     push;
    logic                     pop;
    logic                     fifo_empty;
    logic                     done;
    logic [WIDTH:0]           head;

    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign done       = (ack_a_sync_q[SYNC_STAGES-1] == req_a_q) &
                        (ack_s_sync_q[SYNC_STAGES-1] == req_s_q);

    // Ack synchronisers, oldest sample at the top bit
    always_comb begin
        ack_a_sync_d = {ack_a_sync_q[SYNC_STAGES-2:0], outA_ack};
        ack_s_sync_d = {ack_s_sync_q[SYNC_STAGES-2:0], outSel_ack};
    end

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        req_a_d     = req_a_q;
        req_s_d     = req_s_q;
        data_d      = data_q;
        sel_d       = sel_q;
        sent_d      = sent_q;
        pop         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == '0) begin
                    req_a_d = ~req_a_q;
                    req_s_d = ~req_s_q;
                    state_d = ST_WAIT;
                end else begin
                    setup_cnt_d = setup_cnt_q - SCW'(1);
                end
            end
            ST_WAIT: begin
                if (done) begin
                    sent_d = sent_q + CNT_WIDTH'(1);
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            data_d      = head[WIDTH-1:0];
            sel_d       = head[WIDTH];
            setup_cnt_d = SCW'(SETUP_CYCLES - 1);
        end
    end

    // FIFO bookkeeping; a pushed entry only becomes visible next cycle
    always_comb begin
        push     = in_valid & in_ready_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {in_sel, in_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        in_ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            ack_a_sync_q <= {SYNC_STAGES{REQ_INIT}};
            ack_s_sync_q <= {SYNC_STAGES{REQ_INIT}};
            state_q      <= ST_IDLE;
            setup_cnt_q  <= '0;
            req_a_q      <= REQ_INIT;
            req_s_q      <= REQ_INIT;
            data_q       <= '0;
            sel_q        <= 1'b0;
            sent_q       <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            ack_a_sync_q <= ack_a_sync_d;
            ack_s_sync_q <= ack_s_sync_d;
            state_q      <= state_d;
            setup_cnt_q  <= setup_cnt_d;
            req_a_q      <= req_a_d;
            req_s_q      <= req_s_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            sent_q       <= sent_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign outA_req    = req_a_q;
    assign outSel_req  = req_s_q;
    assign outA_data   = data_q;
    assign outSel_data = sel_q;
    assign busy        = (state_q != ST_IDLE) | !fifo_empty;
    assign fifo_count  = count_q;
    assign tokens_sent = sent_q;

endmodule
